// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for serial_subtractor.
// The ovf member exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;
`endif

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout
`ifdef SERIAL_SUB_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout
`ifdef SERIAL_SUB_OVF_EN
      , output ovf
`endif
   );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin over WIDTH bits, SLICE bits per
// clock through a registered borrow chain. Optional signed-overflow flag is
// built only when SERIAL_SUB_OVF_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start, busy=0 done=0
// RUN    | one slice per edge, down-counter holds slices remaining-1
// DONE   | one-cycle done pulse; start here begins the next operation
module serial_subtractor #(
   parameter int WIDTH = 8,
   parameter int SLICE = 1
) (
   input logic                clk,
   input logic                rst_n,
   serial_subtractor_if.slave io
);
   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic             accept, last;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q, b_q, res_q, res_nxt;
   logic             br_q, br_nxt;
   logic [SLICE-1:0] d_sl;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;
`ifdef SERIAL_SUB_OVF_EN
   logic             a_msb_q, b_msb_q, ovf_q;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode; a terminal count of zero marks the final slice
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      last    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (io.start) begin
               accept  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (cnt_q == '0) begin
               last    = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (io.start) begin
               accept  = 1'b1;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Ripple the low slice of the shifted operands through SLICE subtractor cells
   always_comb begin
      br_nxt = br_q;
      d_sl   = '0;
      for (int i = 0; i < SLICE; i++) begin
         d_sl[i] = a_q[i] ^ b_q[i] ^ br_nxt;
         br_nxt  = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & br_nxt);
      end
   end

   // New slice enters at the top so after N shifts slice 0 sits at bit 0
   assign res_nxt = (res_q >> SLICE) | (WIDTH'(d_sl) << (WIDTH - SLICE));

   // Operand/result datapath; visible outputs move only on the final slice
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         br_q    <= 1'b0;
         res_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else if (accept) begin
         cnt_q   <= CW'(N - 1);
         a_q     <= io.a;
         b_q     <= io.b;
         br_q    <= io.bin;
         res_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb_q <= io.a[WIDTH-1];
         b_msb_q <= io.b[WIDTH-1];
`endif
      end else if (state_q == S_RUN) begin
         a_q   <= a_q >> SLICE;
         b_q   <= b_q >> SLICE;
         br_q  <= br_nxt;
         res_q <= res_nxt;
         if (last) begin
            diff_q <= res_nxt;
            bout_q <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q  <= (a_msb_q ^ b_msb_q) & (res_nxt[WIDTH-1] ^ a_msb_q);
`endif
         end else begin
            cnt_q <= cnt_q - 1'b1;
         end
      end
   end

   assign io.busy = (state_q == S_RUN);
   assign io.done = (state_q == S_DONE);
   assign io.diff = diff_q;
   assign io.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
   assign io.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: three instances (W1/S1, W8/S1,
// W8/S4). Drivers push hand-computed expectations; per-instance monitors pop
// and compare on every done pulse, including the done cycle number.
module tb_serial_subtractor;
   logic clk;
   logic rst_n;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      logic [7:0] d;
      logic       bo;
      logic       ov;
      int         cyc;
   } exp_t;

   exp_t q1[$];
   exp_t q8[$];
   exp_t q4[$];
   exp_t e1, e8, e4;

   serial_subtractor_if #(.WIDTH(1)) i1 ();
   serial_subtractor_if #(.WIDTH(8)) i8 ();
   serial_subtractor_if #(.WIDTH(8)) i4 ();

   serial_subtractor #(.WIDTH(1), .SLICE(1)) u1 (.clk(clk), .rst_n(rst_n), .io(i1.slave));
   serial_subtractor #(.WIDTH(8), .SLICE(1)) u8 (.clk(clk), .rst_n(rst_n), .io(i8.slave));
   serial_subtractor #(.WIDTH(8), .SLICE(4)) u4 (.clk(clk), .rst_n(rst_n), .io(i4.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitors: every done must match the head of its queue
   always @(negedge clk) begin
      if (rst_n && i1.done === 1'b1) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL w1 unexpected done at cycle %0d", cyc);
         end else begin
            e1 = q1.pop_front();
            check("w1 diff", 32'(i1.diff), 32'(e1.d[0]));
            check("w1 bout", 32'(i1.bout), 32'(e1.bo));
            check("w1 done cycle", cyc, e1.cyc);
            check("w1 busy at done", 32'(i1.busy), 0);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && i8.done === 1'b1) begin
         if (q8.size() == 0) begin
            checks++; errors++;
            $display("FAIL w8 unexpected done at cycle %0d", cyc);
         end else begin
            e8 = q8.pop_front();
            check("w8 diff", 32'(i8.diff), 32'(e8.d));
            check("w8 bout", 32'(i8.bout), 32'(e8.bo));
            check("w8 done cycle", cyc, e8.cyc);
            check("w8 busy at done", 32'(i8.busy), 0);
`ifdef SERIAL_SUB_OVF_EN
            check("w8 ovf", 32'(i8.ovf), 32'(e8.ov));
`endif
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && i4.done === 1'b1) begin
         if (q4.size() == 0) begin
            checks++; errors++;
            $display("FAIL w4 unexpected done at cycle %0d", cyc);
         end else begin
            e4 = q4.pop_front();
            check("w4 diff", 32'(i4.diff), 32'(e4.d));
            check("w4 bout", 32'(i4.bout), 32'(e4.bo));
            check("w4 done cycle", cyc, e4.cyc);
`ifdef SERIAL_SUB_OVF_EN
            check("w4 ovf", 32'(i4.ovf), 32'(e4.ov));
`endif
         end
      end
   end

   function automatic int qsize(input int which);
      case (which)
         0:       return q1.size();
         1:       return q8.size();
         default: return q4.size();
      endcase
   endfunction

   task automatic wait_empty(input int which);
      int t = 0;
      while (qsize(which) != 0 && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (qsize(which) != 0) begin
         checks++; errors++;
         $display("FAIL timeout waiting for done on instance %0d (cycle %0d)", which, cyc);
      end
      @(negedge clk);
   endtask

   // One operation: accept on the next edge, done expected N edges later
   task automatic issue(input int which, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input logic [7:0] ed, input logic eb,
                        input logic eo);
      exp_t e;
      @(negedge clk);
      e.d  = ed;
      e.bo = eb;
      e.ov = eo;
      case (which)
         0: begin
            e.cyc = cyc + 1 + 1;
            i1.a = a[0]; i1.b = b[0]; i1.bin = bin; i1.start = 1'b1;
            q1.push_back(e);
         end
         1: begin
            e.cyc = cyc + 1 + 8;
            i8.a = a; i8.b = b; i8.bin = bin; i8.start = 1'b1;
            q8.push_back(e);
         end
         default: begin
            e.cyc = cyc + 1 + 2;
            i4.a = a; i4.b = b; i4.bin = bin; i4.start = 1'b1;
            q4.push_back(e);
         end
      endcase
      @(negedge clk);
      i1.start = 1'b0;
      i8.start = 1'b0;
      i4.start = 1'b0;
      wait_empty(which);
   endtask

   logic [7:0] tt_d;
   logic [7:0] tt_b;
   exp_t       eb2b;
   int         k;

   initial begin
      rst_n = 1'b0;
      i1.start = 1'b0; i1.a = '0; i1.b = '0; i1.bin = 1'b0;
      i8.start = 1'b0; i8.a = '0; i8.b = '0; i8.bin = 1'b0;
      i4.start = 1'b0; i4.a = '0; i4.b = '0; i4.bin = 1'b0;
      repeat (3) @(negedge clk);

      check("reset w1 busy", 32'(i1.busy), 0);
      check("reset w1 done", 32'(i1.done), 0);
      check("reset w8 busy", 32'(i8.busy), 0);
      check("reset w8 done", 32'(i8.done), 0);
      check("reset w8 diff", 32'(i8.diff), 0);
      check("reset w8 bout", 32'(i8.bout), 0);
      check("reset w4 busy", 32'(i4.busy), 0);
      check("reset w4 diff", 32'(i4.diff), 0);
`ifdef SERIAL_SUB_OVF_EN
      check("reset w8 ovf", 32'(i8.ovf), 0);
`endif
      rst_n = 1'b1;

      // Full-subtractor truth table, index = {a,b,bin}
      tt_d = 8'b1001_0110;
      tt_b = 8'b1000_1110;
      for (int v = 0; v < 8; v++) begin
         issue(0, 8'(v[2]), 8'(v[1]), v[0], 8'(tt_d[v]), tt_b[v], 1'b0);
      end

      // Serial 8-bit vectors
      issue(1, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
      issue(1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
      issue(1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
      issue(1, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

      // Nibble-slice vectors
      issue(2, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
      issue(2, 8'h3C, 8'h5A, 1'b1, 8'hE1, 1'b1, 1'b0);

      // Back-to-back with start held through DONE; operands changed mid-RUN
      @(negedge clk);
      k = cyc + 1;
      i4.a = 8'hFF; i4.b = 8'hFF; i4.bin = 1'b1; i4.start = 1'b1;
      eb2b.d = 8'hFF; eb2b.bo = 1'b1; eb2b.ov = 1'b0; eb2b.cyc = k + 2;
      q4.push_back(eb2b);
      @(negedge clk);
      i4.a = 8'h10; i4.b = 8'h01; i4.bin = 1'b0;
      eb2b.d = 8'h0F; eb2b.bo = 1'b0; eb2b.ov = 1'b0; eb2b.cyc = k + 5;
      q4.push_back(eb2b);
      repeat (3) @(negedge clk);
      check("w4 busy after back-to-back accept", 32'(i4.busy), 1);
      i4.start = 1'b0;
      wait_empty(2);
      repeat (3) @(negedge clk);

      // start pulsed mid-RUN with new operands must be ignored
      @(negedge clk);
      k = cyc + 1;
      i8.a = 8'h05; i8.b = 8'h03; i8.bin = 1'b0; i8.start = 1'b1;
      eb2b.d = 8'h02; eb2b.bo = 1'b0; eb2b.ov = 1'b0; eb2b.cyc = k + 8;
      q8.push_back(eb2b);
      @(negedge clk);
      i8.start = 1'b0;
      i8.a = 8'hFF;
      repeat (2) @(negedge clk);
      i8.a = 8'hFF; i8.b = 8'h00; i8.bin = 1'b1; i8.start = 1'b1;
      @(negedge clk);
      i8.start = 1'b0;
      check("w8 busy mid-run", 32'(i8.busy), 1);
      check("w8 diff hidden mid-run", 32'(i8.diff), 32'h80);
      wait_empty(1);
      repeat (12) @(negedge clk);

      // Abort by reset at cycle 3 of a run; no done may follow
      @(negedge clk);
      i8.a = 8'h00; i8.b = 8'h01; i8.bin = 1'b0; i8.start = 1'b1;
      @(negedge clk);
      i8.start = 1'b0;
      repeat (3) @(negedge clk);
      check("w8 busy before abort", 32'(i8.busy), 1);
      rst_n = 1'b0;
      #1;
      check("abort busy", 32'(i8.busy), 0);
      check("abort done", 32'(i8.done), 0);
      check("abort diff", 32'(i8.diff), 0);
      check("abort bout", 32'(i8.bout), 0);
      i8.a = 8'h80; i8.b = 8'h01; i8.start = 1'b1;
      repeat (2) @(negedge clk);
      i8.start = 1'b0;
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("w8 idle after release", 32'(i8.busy), 0);
      check("w8 diff still cleared", 32'(i8.diff), 0);
      issue(1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);

      repeat (3) @(negedge clk);
      check("w1 queue drained", 32'(q1.size()), 0);
      check("w8 queue drained", 32'(q8.size()), 0);
      check("w4 queue drained", 32'(q4.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global time limit reached (cycle %0d)", cyc);
      $fatal(1, "time limit");
   end
endmodule
